// File: rtl/bus_rr_arbiter_if.sv
// Internal bus ownership interface: request vector in, grant/select out.
// master = arbiter side, slave = requester/bus-mux side.
//   req       requester -> arbiter, one bit per source
//   grant     one-hot owner, zero when the bus is unowned
//   bus_sel   binary owner index for the bus mux select
//   bus_valid high when grant is non-zero
//   idle      high while the arbiter is in IDLE
interface bus_rr_arbiter_if #(
   parameter int N_REQ = 16,
   parameter int SEL_W = 4
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic [SEL_W-1:0] bus_sel;
   logic             bus_valid;
   logic             idle;

   modport master (
      input  req,
      output grant,
      output bus_sel,
      output bus_valid,
      output idle
   );

   modport slave (
      output req,
      input  grant,
      input  bus_sel,
      input  bus_valid,
      input  idle
   );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner arbiter for the shared 32-bit internal bus.
// Ports: clk, rst (async, active-high), bus (bus_rr_arbiter_if.master).
module bus_rr_arbiter #(
   parameter int N_REQ    = 16,
   parameter int SEL_W    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              rst,
   bus_rr_arbiter_if.master  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_REL   = 2'd2;

   localparam int HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam int HOLD_MAX = (MAX_HOLD > 0) ? MAX_HOLD : 0;

   logic [1:0]       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic             valid_q, valid_d;
   logic             idle_q, idle_d;

   logic             win_vld;
   logic [SEL_W-1:0] win_idx;
   int               idx;
   logic             own_req;
   logic             others;
   logic             preempt;
   logic [SEL_W-1:0] ptr_nxt;

   // Scan downward so the last hit is the one closest to ptr.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (bus.req[idx]) begin
            win_vld = 1'b1;
            win_idx = SEL_W'(idx);
         end
      end
   end

   assign own_req = bus.req[sel_q];
   assign others  = |(bus.req & ~grant_q);
   // Once the limit is reached (or saturated past it), any waiter preempts.
   assign preempt = (MAX_HOLD != 0) && others &&
                    (hold_q >= HW'(HOLD_LIM));
   assign ptr_nxt = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      unique case (state_q)
         ST_IDLE, ST_REL: begin
            grant_d = '0;
            if (win_vld) begin
               state_d = ST_GRANT;
               grant_d = N_REQ'(1) << win_idx;
               sel_d   = win_idx;
               hold_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!own_req || preempt) begin
               state_d = ST_REL;
               grant_d = '0;
               ptr_d   = ptr_nxt;
            end else if (hold_q != HW'(HOLD_MAX)) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   assign valid_d = (state_d == ST_GRANT);
   assign idle_d  = (state_d == ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         valid_q <= 1'b0;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         idle_q  <= idle_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.bus_sel   = sel_q;
   assign bus.bus_valid = valid_q;
   assign bus.idle      = idle_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: vector table, corner
// sequences and random traffic against a behavioural model.
module tb_bus_rr_arbiter;

   localparam int N    = 16;
   localparam int MAXH = 8;
   localparam int BOUND = (N - 1) * (MAXH + 1) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bus_rr_arbiter_if #(.N_REQ(N), .SEL_W(4)) bif ();

   bus_rr_arbiter #(.N_REQ(N), .SEL_W(4), .MAX_HOLD(MAXH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.master)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: mode 0 = idle, 1 = owned, 2 = dead cycle.
   int m_mode, m_owner, m_last, m_start, m_owned;
   int waitc [N];
   int max_wait;

   typedef struct {
      logic [15:0] req;
      logic [15:0] grant;
      logic [3:0]  sel;
      logic        valid;
      logic        idle;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int pick(input logic [15:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (start + k) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic m_reset();
      m_mode  = 0;
      m_owner = 0;
      m_last  = 0;
      m_start = 0;
      m_owned = 0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
   endtask

   task automatic m_step(input logic [15:0] r);
      logic [15:0] oth;
      if (m_mode == 1) begin
         oth = r & ~(16'h1 << m_owner);
         if (!r[m_owner] || (m_owned >= MAXH && oth != 0)) begin
            m_mode  = 2;
            m_start = (m_owner + 1) % N;
         end else begin
            m_owned++;
         end
      end else if (r != 0) begin
         m_owner = pick(r, m_start);
         m_last  = m_owner;
         m_owned = 1;
         m_mode  = 1;
      end else begin
         m_mode = 0;
      end
   endtask

   task automatic check_all();
      logic [15:0] eg;
      logic [15:0] g;
      eg = (m_mode == 1) ? (16'h1 << m_owner) : 16'h0;
      g  = bif.grant;
      chk("model_grant", 32'(g), 32'(eg));
      chk("model_sel", 32'(bif.bus_sel), 32'(m_last));
      chk("model_valid", 32'(bif.bus_valid), 32'(m_mode == 1));
      chk("model_idle", 32'(bif.idle), 32'(m_mode == 0));
      chk("inv_onehot", 32'((g & (g - 16'h1)) == 16'h0), 32'd1);
      chk("inv_valid", 32'(bif.bus_valid), 32'(|g));
      chk("inv_sel", 32'(g[bif.bus_sel]), 32'(bif.bus_valid));
   endtask

   task automatic apply(input logic [15:0] r);
      bif.req = r;
      @(posedge clk);
      m_step(r);
      #1;
      check_all();
      for (int i = 0; i < N; i++) begin
         if (r[i] && !bif.grant[i]) waitc[i]++;
         else waitc[i] = 0;
         if (waitc[i] > max_wait) max_wait = waitc[i];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bif.req = '0;
      rst = 1'b1;
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] r;
      int cnt;

      vt[0] = '{16'h0004, 16'h0004, 4'd2, 1'b1, 1'b0};
      vt[1] = '{16'h0000, 16'h0000, 4'd2, 1'b0, 1'b0};
      vt[2] = '{16'h0000, 16'h0000, 4'd2, 1'b0, 1'b1};
      vt[3] = '{16'h0011, 16'h0010, 4'd4, 1'b1, 1'b0};
      vt[4] = '{16'h0001, 16'h0000, 4'd4, 1'b0, 1'b0};
      vt[5] = '{16'h0001, 16'h0001, 4'd0, 1'b1, 1'b0};
      vt[6] = '{16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
      vt[7] = '{16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1};

      max_wait = 0;
      bif.req = '0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 32'(bif.grant), 32'd0);
      chk("rst_idle", 32'(bif.idle), 32'd1);
      do_reset();

      for (int v = 0; v < 8; v++) begin
         apply(vt[v].req);
         chk($sformatf("vec%0d_grant", v), 32'(bif.grant), 32'(vt[v].grant));
         chk($sformatf("vec%0d_sel", v), 32'(bif.bus_sel), 32'(vt[v].sel));
         chk($sformatf("vec%0d_valid", v), 32'(bif.bus_valid), 32'(vt[v].valid));
         chk($sformatf("vec%0d_idle", v), 32'(bif.idle), 32'(vt[v].idle));
      end

      // Simultaneous requests after reset.
      do_reset();
      apply(16'h0011);
      chk("sim_first", 32'(bif.grant), 32'h0001);
      apply(16'h0010);
      chk("sim_dead", 32'(bif.grant), 32'h0);
      apply(16'h0010);
      chk("sim_second", 32'(bif.grant), 32'h0010);
      chk("sim_sel", 32'(bif.bus_sel), 32'd4);

      // Wrap-around from owner 15.
      do_reset();
      apply(16'h8000);
      chk("wrap_own15", 32'(bif.bus_sel), 32'd15);
      apply(16'hC001);
      apply(16'h4001);
      chk("wrap_dead", 32'(bif.bus_valid), 32'd0);
      chk("wrap_dead_sel", 32'(bif.bus_sel), 32'd15);
      apply(16'h4001);
      chk("wrap_grant0", 32'(bif.grant), 32'h0001);

      // Preemption after exactly MAX_HOLD cycles.
      do_reset();
      apply(16'h0001);
      cnt = (bif.grant == 16'h0001) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         apply(16'h0009);
         if (bif.grant == 16'h0001) cnt++;
         else break;
      end
      chk("pre_len", 32'(cnt), 32'(MAXH));
      chk("pre_dead", 32'(bif.grant), 32'h0);
      apply(16'h0009);
      chk("pre_grant3", 32'(bif.grant), 32'h0008);
      apply(16'h0001);
      chk("pre_rel3", 32'(bif.grant), 32'h0);
      apply(16'h0001);
      chk("pre_regrant0", 32'(bif.grant), 32'h0001);

      // No contention: grant held indefinitely.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         apply(16'h0001);
         chk("solo_hold", 32'(bif.grant), 32'h0001);
      end

      // Asynchronous reset mid-grant, then search restarts at 0.
      do_reset();
      apply(16'h0010);
      apply(16'h0000);
      apply(16'h0020);
      apply(16'h0020);
      chk("arst_pre", 32'(bif.grant), 32'h0020);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_grant", 32'(bif.grant), 32'h0);
      chk("arst_valid", 32'(bif.bus_valid), 32'd0);
      chk("arst_sel", 32'(bif.bus_sel), 32'd0);
      chk("arst_idle", 32'(bif.idle), 32'd1);
      m_reset();
      bif.req = '0;
      @(negedge clk);
      rst = 1'b0;
      apply(16'h0041);
      chk("arst_ptr0", 32'(bif.grant), 32'h0001);

      // Random traffic against the model.
      do_reset();
      r = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(9) == 0) r[i] = ~r[i];
         apply(r);
      end
      chk("starvation", 32'(max_wait <= BOUND), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
